// File: rtl/rbit_pkg.sv
// Shared constants, FSM state type and the Galois LFSR step for the random-bit source.
package rbit_pkg;

  localparam int unsigned RBIT_LFSR_W = 16;
  localparam logic [RBIT_LFSR_W-1:0] RBIT_TAPS = 16'hB400;
  localparam logic [RBIT_LFSR_W-1:0] RBIT_DEFAULT_SEED = 16'hACE1;
  localparam int unsigned RBIT_DIV_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SEED,
    RUN,
    HOLD
  } state_e;

  // Returns {next_lfsr, emitted_bit}; the emitted bit is the one shifted out of bit 0.
  function automatic logic [RBIT_LFSR_W:0] lfsr_step(
    input logic [RBIT_LFSR_W-1:0] s,
    input logic [RBIT_LFSR_W-1:0] taps
  );
    return {(s >> 1) ^ (s[0] ? taps : '0), s[0]};
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Galois LFSR register with serial seed load, step and default-reload controls.
module lfsr_core
  import rbit_pkg::*;
#(
  parameter int unsigned       LFSR_W       = RBIT_LFSR_W,
  parameter logic [LFSR_W-1:0] TAPS         = RBIT_TAPS,
  parameter logic [LFSR_W-1:0] DEFAULT_SEED = RBIT_DEFAULT_SEED
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic load_serial_i,
  input  logic seed_bit_i,
  input  logic step_i,
  input  logic reload_default_i,
  output logic bit_o,
  output logic zero_o
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [LFSR_W:0]   step_res;

  always_comb begin
    step_res = lfsr_step(lfsr_q, TAPS);
    lfsr_d   = lfsr_q;
    if (reload_default_i) begin
      lfsr_d = DEFAULT_SEED;
    end else if (load_serial_i) begin
      lfsr_d = {seed_bit_i, lfsr_q[LFSR_W-1:1]};
    end else if (step_i) begin
      lfsr_d = step_res[LFSR_W:1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      lfsr_q <= DEFAULT_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign bit_o  = step_res[0];
  assign zero_o = (lfsr_q == '0);

endmodule

// File: rtl/rbit_source.sv
// Serial random-bit source: prescaled Galois LFSR, serial seed load, valid/ready output.
// Optional Von Neumann debiasing of raw LFSR pairs when RBIT_VON_NEUMANN_EN is defined.
module rbit_source
  import rbit_pkg::*;
#(
  parameter int unsigned       LFSR_W       = RBIT_LFSR_W,
  parameter logic [LFSR_W-1:0] TAPS         = RBIT_TAPS,
  parameter logic [LFSR_W-1:0] DEFAULT_SEED = RBIT_DEFAULT_SEED,
  parameter int unsigned       DIV_W        = RBIT_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic             seed_we,
  input  logic             seed_bit,
  output logic             rbit,
  output logic             rbit_valid,
  input  logic             rbit_ready,
  output logic             lockup
);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             rbit_q, rbit_d;
  logic             valid_q, valid_d;
  logic             lockup_q, lockup_d;

  logic load_serial, step, reload;
  logic raw_bit, lfsr_zero;
  logic tick, xfer, emit, out_bit;

  lfsr_core #(
    .LFSR_W      (LFSR_W),
    .TAPS        (TAPS),
    .DEFAULT_SEED(DEFAULT_SEED)
  ) u_core (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .load_serial_i   (load_serial),
    .seed_bit_i      (seed_bit),
    .step_i          (step),
    .reload_default_i(reload),
    .bit_o           (raw_bit),
    .zero_o          (lfsr_zero)
  );

  assign tick = (cnt_q == div);
  assign xfer = valid_q && rbit_ready;

`ifdef RBIT_VON_NEUMANN_EN
  logic pair_q, pair_d;
  logic first_q, first_d;

  // A step only produces output on the second bit of an unequal pair; the first bit is emitted.
  assign emit    = pair_q && (first_q != raw_bit);
  assign out_bit = first_q;

  always_comb begin
    pair_d  = pair_q;
    first_d = first_q;
    if (seed_we || !en || reload) begin
      pair_d = 1'b0;
    end else if (step) begin
      if (!pair_q) begin
        pair_d  = 1'b1;
        first_d = raw_bit;
      end else begin
        pair_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pair_q  <= 1'b0;
      first_q <= 1'b0;
    end else begin
      pair_q  <= pair_d;
      first_q <= first_d;
    end
  end
`else
  assign emit    = 1'b1;
  assign out_bit = raw_bit;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rbit_d      = rbit_q;
    valid_d     = valid_q;
    lockup_d    = 1'b0;
    load_serial = 1'b0;
    step        = 1'b0;
    reload      = 1'b0;

    if (seed_we) begin
      state_d     = SEED;
      load_serial = 1'b1;
      valid_d     = 1'b0;
      cnt_d       = '0;
    end else if (state_q == SEED) begin
      state_d = en ? RUN : IDLE;
      cnt_d   = '0;
      valid_d = 1'b0;
      if (lfsr_zero) begin
        reload   = 1'b1;
        lockup_d = 1'b1;
      end
    end else if (!en) begin
      state_d = IDLE;
      valid_d = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = RUN;
          cnt_d   = '0;
        end
        RUN: begin
          if (lfsr_zero) begin
            reload   = 1'b1;
            lockup_d = 1'b1;
            cnt_d    = '0;
            if (xfer) valid_d = 1'b0;
          end else if (tick) begin
            // Park the step rather than overwrite a bit the consumer has not taken.
            if (emit && valid_q && !rbit_ready) begin
              state_d = HOLD;
            end else begin
              step  = 1'b1;
              cnt_d = '0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (xfer) valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (lfsr_zero) begin
            reload   = 1'b1;
            lockup_d = 1'b1;
            cnt_d    = '0;
            state_d  = RUN;
            if (xfer) valid_d = 1'b0;
          end else if (xfer) begin
            step    = 1'b1;
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            cnt_d = div;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (step) begin
      if (emit) begin
        rbit_d  = out_bit;
        valid_d = 1'b1;
      end else if (xfer) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rbit_q   <= 1'b0;
      valid_q  <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rbit_q   <= rbit_d;
      valid_q  <= valid_d;
      lockup_q <= lockup_d;
    end
  end

  assign rbit       = rbit_q;
  assign rbit_valid = valid_q;
  assign lockup     = lockup_q;

endmodule

// File: tb/tb_rbit_source.sv
// Scoreboard bench for rbit_source: reference bit stream from the Galois rule, checked per transfer.
module tb_rbit_source;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] div;
  logic       seed_we;
  logic       seed_bit;
  logic       rbit;
  logic       rbit_valid;
  logic       rbit_ready;
  logic       lockup;

  int          tests = 0;
  int          fails = 0;
  bit          exp_q[$];
  int unsigned cyc = 0;
  int unsigned last_xfer = 0;
  int unsigned spacing_exp = 0;
  int unsigned lock_cnt = 0;
  bit          have_last = 0;
  bit          chk_spacing = 0;
  bit          mon_e;
  logic [15:0] rs;
  logic [7:0]  rdiv;

  rbit_source dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .div       (div),
    .seed_we   (seed_we),
    .seed_bit  (seed_bit),
    .rbit      (rbit),
    .rbit_valid(rbit_valid),
    .rbit_ready(rbit_ready),
    .lockup    (lockup)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // Monitor: every accepted transfer is compared against the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (lockup === 1'b1) lock_cnt++;
      if (rbit_valid === 1'b1 && rbit_ready === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL xfer_unexpected: got rbit=%0b at cycle %0d, required no transfer", rbit, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (rbit !== mon_e) begin
            fails++;
            $display("FAIL xfer_bit: got rbit=%0b, required %0b (cycle %0d)", rbit, mon_e, cyc);
          end
        end
        if (chk_spacing && have_last) begin
          tests++;
          if (cyc - last_xfer != spacing_exp) begin
            fails++;
            $display("FAIL xfer_spacing: got %0d cycles, required %0d", cyc - last_xfer, spacing_exp);
          end
        end
        last_xfer = cyc;
        have_last = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mstep(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Expected output bits from a seed (zero seed behaves as the default seed after recovery).
  task automatic push_stream(input logic [15:0] seed, input int n);
    logic [15:0] s;
    bit          b;
    bit          have;
    bit          f;
    int          cnt;
    s    = (seed == 16'h0000) ? 16'hACE1 : seed;
    have = 1'b0;
    f    = 1'b0;
    cnt  = 0;
    while (cnt < n) begin
      b = s[0];
      s = mstep(s);
`ifdef RBIT_VON_NEUMANN_EN
      if (!have) begin
        f    = b;
        have = 1'b1;
      end else begin
        have = 1'b0;
        if (f != b) begin
          exp_q.push_back(f);
          cnt++;
        end
      end
`else
      exp_q.push_back(b);
      cnt++;
`endif
    end
  endtask

  task automatic do_reset(input logic en_v, input logic [7:0] div_v, input logic rdy_v);
    rst_n      = 1'b0;
    en         = en_v;
    div        = div_v;
    rbit_ready = rdy_v;
    seed_we    = 1'b0;
    seed_bit   = 1'b0;
    exp_q.delete();
    have_last   = 1'b0;
    chk_spacing = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", rbit_valid, 0);
    check("reset_rbit", rbit, 0);
    check("reset_lockup", lockup, 0);
    lock_cnt = 0;
    rst_n    = 1'b1;
  endtask

  task automatic load_seed(input logic [15:0] s, input logic en_load, input logic en_after);
    en      = en_load;
    seed_we = 1'b1;
    for (int i = 0; i < 16; i++) begin
      seed_bit = s[i];
      @(posedge clk);
      #1;
    end
    seed_we  = 1'b0;
    seed_bit = 1'b0;
    en       = en_after;
  endtask

  task automatic drain(input string name, input bit rand_ready, input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clk);
      #1;
      if (rand_ready) rbit_ready = 1'($urandom_range(0, 1));
      k++;
    end
    rbit_ready = 1'b0;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: got %0d bits pending after %0d cycles, required 0", name, exp_q.size(), k);
      exp_q.delete();
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; div = '0; seed_we = 1'b0; seed_bit = 1'b0; rbit_ready = 1'b0;

    // Back-to-back stream from the default seed
    do_reset(1'b1, 8'd0, 1'b1);
    push_stream(16'hACE1, 7);
`ifndef RBIT_VON_NEUMANN_EN
    chk_spacing = 1'b1;
    spacing_exp = 1;
`endif
    @(posedge clk); #1;
    check("first_edge_valid", rbit_valid, 0);
`ifndef RBIT_VON_NEUMANN_EN
    @(posedge clk); #1;
    check("first_tick_valid_bit", {rbit_valid, rbit}, 2'b11);
`endif
    drain("default_seq", 1'b0, 100);

    // Prescaled stream, one bit per div+1 cycles
    do_reset(1'b1, 8'd3, 1'b1);
    push_stream(16'hACE1, 6);
`ifndef RBIT_VON_NEUMANN_EN
    chk_spacing = 1'b1;
    spacing_exp = 4;
`endif
    drain("div3", 1'b0, 200);

    // Consumer stalls: the presented bit stays frozen and no bit is lost
    do_reset(1'b1, 8'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) begin
      check("stall_hold", {rbit_valid, rbit}, 2'b11);
      @(posedge clk);
      #1;
    end
    push_stream(16'hACE1, 6);
    rbit_ready = 1'b1;
    drain("stall_release", 1'b0, 100);

    // All-zero seed triggers lock-up recovery
    do_reset(1'b0, 8'd0, 1'b1);
    load_seed(16'h0000, 1'b0, 1'b1);
    push_stream(16'h0000, 5);
    @(posedge clk); #1;
    check("lockup_pulse", lockup, 1);
    @(posedge clk); #1;
    check("lockup_clear", lockup, 0);
    drain("lockup_seq", 1'b0, 100);
    check("lockup_count", lock_cnt, 1);

    // Seed 0x0001, stall, drop enable, resume from the retained state
    do_reset(1'b0, 8'd0, 1'b0);
    load_seed(16'h0001, 1'b1, 1'b1);
    begin
      int k;
      k = 0;
      while (rbit_valid !== 1'b1 && k < 8) begin
        @(posedge clk);
        #1;
        k++;
      end
    end
    check("seed1_first_bit", {rbit_valid, rbit}, 2'b11);
    repeat (2) @(posedge clk);
    #1;
    check("seed1_hold", {rbit_valid, rbit}, 2'b11);
    en = 1'b0;
    @(posedge clk); #1;
    check("en_drop_valid", rbit_valid, 0);
    check("en_drop_rbit", rbit, 1);
    check("seed1_no_lockup", lock_cnt, 0);
`ifndef RBIT_VON_NEUMANN_EN
    push_stream(16'hB400, 8);
    en         = 1'b1;
    rbit_ready = 1'b1;
    drain("resume", 1'b0, 100);
`endif

    // Random seeds, prescaler values and consumer backpressure
    for (int r = 0; r < 12; r++) begin
      rdiv = 8'($urandom_range(0, 4));
      do_reset(1'b0, rdiv, 1'b0);
      rs = 16'($urandom_range(1, 65535));
      load_seed(rs, 1'($urandom_range(0, 1)), 1'b1);
      push_stream(rs, 10);
      rbit_ready = 1'($urandom_range(0, 1));
      drain("rand", 1'b1, 1500);
      check("rand_no_lockup", lock_cnt, 0);
    end

    do_reset(1'b0, 8'd0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rbit_source.md
Name: rbit_source

Overview:
- Serial random-bit transmitter feeding the `rbit` input of the cookie game core.
- Galois LFSR with a programmable prescaler, a serial seed-load path and a valid/ready output handshake.
- Guards against LFSR all-zero lock-up.
- Sits beside the cookie core in the top level: the source's `rbit` drives the core's `rbit`, and `en` is shared.

Parameters:
- LFSR_W, 16, LFSR width in bits.
- TAPS, 16'hB400, Galois feedback mask, XORed in when the shifted-out bit is 1.
- DEFAULT_SEED, 16'hACE1, seed used at reset and on lock-up recovery; must be nonzero.
- DIV_W, 8, prescaler width.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- en  input  1  run enable.
- div  input  DIV_W  bit period minus one; one LFSR step per div+1 enabled cycles.
- seed_we  input  1  serial seed shift enable.
- seed_bit  input  1  serial seed data, LSB first.
- rbit  output  1  random bit, stable while rbit_valid=1.
- rbit_valid  output  1  rbit holds a fresh, unconsumed bit.
- rbit_ready  input  1  consumer accepts; transfer occurs when valid&&ready.
- lockup  output  1  one-cycle pulse when the all-zero state is detected and the LFSR is reloaded.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - lfsr=DEFAULT_SEED, cnt=0, rbit=0, rbit_valid=0, lockup=0, state=IDLE.
  - Reset mid-operation aborts any seed load or pending bit.
- Galois step:
  - b=lfsr[0]; lfsr<=(lfsr>>1)^(b?TAPS:0); the emitted bit is b.
  - Emitted sequence from 0xACE1: 1,0,0,0,0,1,1,...
- States: IDLE, SEED, RUN, HOLD.
- Priority: seed_we over en; en=0 returns to IDLE.
- IDLE:
  - rbit_valid=0, cnt=0, lfsr retained.
  - en=1 and seed_we=0 go to RUN.
- SEED (any state with seed_we=1):
  - lfsr<={seed_bit,lfsr[W-1:1]} each cycle; rbit_valid<=0; cnt<=0.
  - After exactly LFSR_W cycles, the first bit shifted in lands in lfsr[0].
  - Partial loads are allowed and keep the older bits.
  - On seed_we falling, go to RUN if en=1, else IDLE.
- RUN:
  - cnt increments each cycle.
  - tick = (cnt==div); on tick, cnt<=0 and the LFSR steps.
  - The emitted bit is registered into rbit with rbit_valid<=1 the next cycle (latency 1 from tick).
  - div=0 gives a tick every cycle.
- Handshake:
  - valid&&ready with no tick: rbit_valid<=0.
  - valid&&ready with a tick in the same cycle: the new bit is loaded and valid stays 1 (back-to-back, no bubble).
  - A tick arriving while valid=1&&ready=0 moves to HOLD.
- HOLD:
  - cnt saturates at div; lfsr and rbit are frozen; no bits are dropped.
  - The cycle valid&&ready occurs, the pending step executes (bit loaded, valid stays 1); return to RUN with cnt=0.
- Lock-up:
  - Whenever lfsr==0 in RUN/HOLD, or on exit from SEED, lfsr<=DEFAULT_SEED and lockup=1 for one cycle.
  - No bit is emitted that cycle.
- en falling: next cycle rbit_valid=0, cnt=0, lfsr retained; rbit keeps its last value.

Optional Feature:
- Macro: RBIT_VON_NEUMANN_EN.
- Defined: raw LFSR bits are taken in pairs (first, second).
  - (1,0) emits 1.
  - (0,1) emits 0.
  - (0,0) and (1,1) are discarded, with no valid.
  - From DEFAULT_SEED the raw pairs 10,00,01 emit 1, then 0.
  - The pair-phase flag clears on reset, seed load, en=0 and lock-up.
- Undefined: every tick emits one raw bit; no pair logic is synthesized.

Decomposition:
- Package rbit_pkg:
  - LFSR_W default, TAPS, DEFAULT_SEED.
  - State enum {IDLE, SEED, RUN, HOLD}.
  - A step function returning {next_lfsr, bit}.
- Sub-module lfsr_core: register with load_serial, step and reload_default controls; exposes state and zero flag.
- Prescaler, FSM and handshake live in rbit_source.

Test Plan:
- Reset with en=1, div=0, ready=1, no macro -> rbit_valid rises the cycle after the first tick; rbit sequence 1,0,0,0,0,1,1 on consecutive cycles.
- div=3, ready=1 -> valid bits presented every 4 cycles, values matching the same sequence.
- div=0, ready held 0 for 10 cycles, then 1 -> rbit=1 stays frozen with valid=1; after release, the next bits are 0,0,0,0 with no skipped bit.
- Seed 16 zero bits via seed_we, then en=1 -> lockup pulses once; lfsr=0xACE1; sequence restarts 1,0,0,...
- Seed 0x0001 LSB first -> first emitted bit 1, lfsr=0xB400; en dropped mid-run -> valid=0 next cycle; re-enable resumes from the retained lfsr.
- RBIT_VON_NEUMANN_EN defined, default seed, div=0, ready=1 -> valid outputs 1 then 0; no valid on the discarded 00 pair.
